// File: rtl/l1d_pkg.sv
// Shared opcode constants, widths and helper types for the L1D port arbiter.
package l1d_pkg;

   localparam int unsigned OPCODE_W   = 7;
   localparam int unsigned REG_ADDR_W = 5;

   localparam logic [OPCODE_W-1:0] OP_NOP   = 7'd0;
   localparam logic [OPCODE_W-1:0] OP_IMM   = 7'd10;
   localparam logic [OPCODE_W-1:0] OP_LOAD  = 7'd11;
   localparam logic [OPCODE_W-1:0] OP_STORE = 7'd12;

   typedef enum logic {
      PortA = 1'b0,
      PortB = 1'b1
   } port_e;

   typedef enum logic [1:0] {
      OpcNop,
      OpcImm,
      OpcLoad,
      OpcStore
   } op_class_e;

   typedef struct packed {
      logic [OPCODE_W-1:0]   opcode;
      logic                  is_wb;
      logic [REG_ADDR_W-1:0] wb_addr;
   } req_ctrl_t;

   // Illegal opcodes fall through to the nop class.
   function automatic op_class_e op_class(input logic [OPCODE_W-1:0] op);
      op_class_e c;
      case (op)
         OP_IMM:   c = OpcImm;
         OP_LOAD:  c = OpcLoad;
         OP_STORE: c = OpcStore;
         default:  c = OpcNop;
      endcase
      return c;
   endfunction

   function automatic logic op_legal(input logic [OPCODE_W-1:0] op);
      return (op == OP_NOP) || (op == OP_IMM) || (op == OP_LOAD) || (op == OP_STORE);
   endfunction

endpackage

// File: rtl/l1d_req_slot.sv
// One-entry request buffer; frees itself when granted and can refill on the same edge.
module l1d_req_slot
   import l1d_pkg::*;
#(
   parameter int unsigned DATA_W = 16
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [OPCODE_W-1:0]   opcode_i,
   input  logic                  is_wb_i,
   input  logic [REG_ADDR_W-1:0] wb_addr_i,
   input  logic [DATA_W-1:0]     p_operand_i,
   input  logic [DATA_W-1:0]     s_operand_i,
   input  logic                  grant_i,
   output logic                  occupied_o,
   output req_ctrl_t             ctrl_o,
   output logic [DATA_W-1:0]     p_operand_o,
   output logic [DATA_W-1:0]     s_operand_o
);

   logic              occ_q, occ_d;
   req_ctrl_t         ctrl_q, ctrl_d;
   logic [DATA_W-1:0] p_q, p_d;
   logic [DATA_W-1:0] s_q, s_d;
   logic              accept;

   always_comb begin
      ready_o = ~reset_i & (~occ_q | grant_i);
      accept  = valid_i & ready_o;
      occ_d   = occ_q;
      ctrl_d  = ctrl_q;
      p_d     = p_q;
      s_d     = s_q;
      if (grant_i) begin
         occ_d = 1'b0;
      end
      if (accept) begin
         occ_d          = 1'b1;
         ctrl_d.opcode  = opcode_i;
         ctrl_d.is_wb   = is_wb_i;
         ctrl_d.wb_addr = wb_addr_i;
         p_d            = p_operand_i;
         s_d            = s_operand_i;
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         occ_q  <= 1'b0;
         ctrl_q <= '0;
         p_q    <= '0;
         s_q    <= '0;
      end else begin
         occ_q  <= occ_d;
         ctrl_q <= ctrl_d;
         p_q    <= p_d;
         s_q    <= s_d;
      end
   end

   assign occupied_o  = occ_q;
   assign ctrl_o      = ctrl_q;
   assign p_operand_o = p_q;
   assign s_operand_o = s_q;

endmodule

// File: rtl/l1d_port_arbiter.sv
// Two-port round-robin arbiter in front of a synchronous single-port data memory.
// Define L1D_ARB_STATS_EN to add saturating grant/conflict counters.
module l1d_port_arbiter
   import l1d_pkg::*;
#(
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned MEM_DEPTH = 10000
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic                  reqA_valid_i,
   output logic                  reqA_ready_o,
   input  logic [OPCODE_W-1:0]   reqA_opcode_i,
   input  logic                  reqA_isWb_i,
   input  logic [REG_ADDR_W-1:0] reqA_wbAddress_i,
   input  logic [DATA_W-1:0]     reqA_pOperand_i,
   input  logic [DATA_W-1:0]     reqA_sOperand_i,
   input  logic                  reqB_valid_i,
   output logic                  reqB_ready_o,
   input  logic [OPCODE_W-1:0]   reqB_opcode_i,
   input  logic                  reqB_isWb_i,
   input  logic [REG_ADDR_W-1:0] reqB_wbAddress_i,
   input  logic [DATA_W-1:0]     reqB_pOperand_i,
   input  logic [DATA_W-1:0]     reqB_sOperand_i,
   output logic                  rspA_wbEnable_o,
   output logic [REG_ADDR_W-1:0] rspA_wbAddress_o,
   output logic [DATA_W-1:0]     rspA_wbData_o,
   output logic                  rspB_wbEnable_o,
   output logic [REG_ADDR_W-1:0] rspB_wbAddress_o,
   output logic [DATA_W-1:0]     rspB_wbData_o,
   output logic                  mem_en_o,
   output logic                  mem_we_o,
   output logic [DATA_W-1:0]     mem_addr_o,
   output logic [DATA_W-1:0]     mem_wdata_o,
   input  logic [DATA_W-1:0]     mem_rdata_i,
   output logic                  err_o
`ifdef L1D_ARB_STATS_EN
   ,
   output logic [15:0]           stat_grantA_o,
   output logic [15:0]           stat_grantB_o,
   output logic [15:0]           stat_conflict_o
`endif
);

   typedef struct packed {
      logic                  valid;
      port_e                 port;
      op_class_e             cls;
      logic                  is_wb;
      logic [REG_ADDR_W-1:0] wb_addr;
      logic                  oob;
      logic [DATA_W-1:0]     imm;
   } tag_t;

   localparam logic [DATA_W:0] DEPTH_LIM = (DATA_W+1)'(MEM_DEPTH);

   logic              a_occ, b_occ, grant_a, grant_b, contended;
   req_ctrl_t         a_ctrl, b_ctrl, iss_ctrl;
   logic [DATA_W-1:0] a_p, a_s, b_p, b_s, iss_p, iss_s;
   port_e             rr_q, rr_d;
   op_class_e         iss_cls;
   logic              iss_valid, iss_mem, iss_oob;

   logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d, err_q, err_d;
   logic [DATA_W-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
   tag_t              tag1_q, tag1_d, tag2_q;

   logic                  rsp_a_en_q, rsp_a_en_d, rsp_b_en_q, rsp_b_en_d;
   logic [REG_ADDR_W-1:0] rsp_a_addr_q, rsp_a_addr_d, rsp_b_addr_q, rsp_b_addr_d;
   logic [DATA_W-1:0]     rsp_a_data_q, rsp_a_data_d, rsp_b_data_q, rsp_b_data_d;

   l1d_req_slot #(.DATA_W(DATA_W)) u_slot_a (
      .clock_i     (clock_i),
      .reset_i     (reset_i),
      .valid_i     (reqA_valid_i),
      .ready_o     (reqA_ready_o),
      .opcode_i    (reqA_opcode_i),
      .is_wb_i     (reqA_isWb_i),
      .wb_addr_i   (reqA_wbAddress_i),
      .p_operand_i (reqA_pOperand_i),
      .s_operand_i (reqA_sOperand_i),
      .grant_i     (grant_a),
      .occupied_o  (a_occ),
      .ctrl_o      (a_ctrl),
      .p_operand_o (a_p),
      .s_operand_o (a_s)
   );

   l1d_req_slot #(.DATA_W(DATA_W)) u_slot_b (
      .clock_i     (clock_i),
      .reset_i     (reset_i),
      .valid_i     (reqB_valid_i),
      .ready_o     (reqB_ready_o),
      .opcode_i    (reqB_opcode_i),
      .is_wb_i     (reqB_isWb_i),
      .wb_addr_i   (reqB_wbAddress_i),
      .p_operand_i (reqB_pOperand_i),
      .s_operand_i (reqB_sOperand_i),
      .grant_i     (grant_b),
      .occupied_o  (b_occ),
      .ctrl_o      (b_ctrl),
      .p_operand_o (b_p),
      .s_operand_o (b_s)
   );

   // Arbitration and issue decode; the pointer moves to the loser only on contention.
   always_comb begin
      contended = a_occ & b_occ;
      grant_a   = a_occ & (~b_occ | (rr_q == PortA));
      grant_b   = b_occ & (~a_occ | (rr_q == PortB));
      rr_d      = rr_q;
      if (contended) begin
         rr_d = grant_a ? PortB : PortA;
      end
      iss_valid = grant_a | grant_b;
      iss_ctrl  = grant_b ? b_ctrl : a_ctrl;
      iss_p     = grant_b ? b_p : a_p;
      iss_s     = grant_b ? b_s : a_s;
      iss_cls   = op_class(iss_ctrl.opcode);
      iss_mem   = (iss_cls == OpcLoad) | (iss_cls == OpcStore);
      iss_oob   = iss_mem & ({1'b0, iss_s} >= DEPTH_LIM);

      mem_en_d    = iss_valid & iss_mem & ~iss_oob;
      mem_we_d    = mem_en_d & (iss_cls == OpcStore);
      mem_addr_d  = iss_valid ? iss_s : '0;
      mem_wdata_d = mem_we_d ? iss_p : '0;
      err_d       = iss_valid & (~op_legal(iss_ctrl.opcode) | iss_oob);

      tag1_d         = '0;
      tag1_d.valid   = iss_valid;
      tag1_d.port    = grant_b ? PortB : PortA;
      tag1_d.cls     = iss_cls;
      tag1_d.is_wb   = iss_ctrl.is_wb;
      tag1_d.wb_addr = iss_ctrl.wb_addr;
      tag1_d.oob     = iss_oob;
      tag1_d.imm     = iss_s;
   end

   // Writeback stage: read data is valid one edge after the memory stage samples.
   always_comb begin
      logic              wb_en;
      logic [DATA_W-1:0] wb_data;
      wb_en   = 1'b0;
      wb_data = '0;
      if (tag2_q.valid) begin
         unique case (tag2_q.cls)
            OpcLoad: begin
               wb_en   = tag2_q.is_wb;
               wb_data = tag2_q.oob ? '0 : mem_rdata_i;
            end
            OpcImm: begin
               wb_en   = tag2_q.is_wb;
               wb_data = tag2_q.imm;
            end
            default: begin
               wb_en   = 1'b0;
               wb_data = '0;
            end
         endcase
      end
      rsp_a_en_d   = 1'b0;
      rsp_a_addr_d = '0;
      rsp_a_data_d = '0;
      rsp_b_en_d   = 1'b0;
      rsp_b_addr_d = '0;
      rsp_b_data_d = '0;
      if (tag2_q.valid && tag2_q.port == PortA) begin
         rsp_a_en_d   = wb_en;
         rsp_a_addr_d = wb_en ? tag2_q.wb_addr : '0;
         rsp_a_data_d = wb_data;
      end
      if (tag2_q.valid && tag2_q.port == PortB) begin
         rsp_b_en_d   = wb_en;
         rsp_b_addr_d = wb_en ? tag2_q.wb_addr : '0;
         rsp_b_data_d = wb_data;
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         rr_q         <= PortA;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         err_q        <= 1'b0;
         tag1_q       <= '0;
         tag2_q       <= '0;
         rsp_a_en_q   <= 1'b0;
         rsp_a_addr_q <= '0;
         rsp_a_data_q <= '0;
         rsp_b_en_q   <= 1'b0;
         rsp_b_addr_q <= '0;
         rsp_b_data_q <= '0;
      end else begin
         rr_q         <= rr_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         err_q        <= err_d;
         tag1_q       <= tag1_d;
         tag2_q       <= tag1_q;
         rsp_a_en_q   <= rsp_a_en_d;
         rsp_a_addr_q <= rsp_a_addr_d;
         rsp_a_data_q <= rsp_a_data_d;
         rsp_b_en_q   <= rsp_b_en_d;
         rsp_b_addr_q <= rsp_b_addr_d;
         rsp_b_data_q <= rsp_b_data_d;
      end
   end

   assign mem_en_o         = mem_en_q;
   assign mem_we_o         = mem_we_q;
   assign mem_addr_o       = mem_addr_q;
   assign mem_wdata_o      = mem_wdata_q;
   assign err_o            = err_q;
   assign rspA_wbEnable_o  = rsp_a_en_q;
   assign rspA_wbAddress_o = rsp_a_addr_q;
   assign rspA_wbData_o    = rsp_a_data_q;
   assign rspB_wbEnable_o  = rsp_b_en_q;
   assign rspB_wbAddress_o = rsp_b_addr_q;
   assign rspB_wbData_o    = rsp_b_data_q;

`ifdef L1D_ARB_STATS_EN
   logic [15:0] stat_a_q, stat_a_d, stat_b_q, stat_b_d, stat_c_q, stat_c_d;

   always_comb begin
      stat_a_d = stat_a_q;
      stat_b_d = stat_b_q;
      stat_c_d = stat_c_q;
      if (grant_a && stat_a_q != 16'hFFFF) stat_a_d = stat_a_q + 16'd1;
      if (grant_b && stat_b_q != 16'hFFFF) stat_b_d = stat_b_q + 16'd1;
      if (contended && stat_c_q != 16'hFFFF) stat_c_d = stat_c_q + 16'd1;
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         stat_a_q <= '0;
         stat_b_q <= '0;
         stat_c_q <= '0;
      end else begin
         stat_a_q <= stat_a_d;
         stat_b_q <= stat_b_d;
         stat_c_q <= stat_c_d;
      end
   end

   assign stat_grantA_o   = stat_a_q;
   assign stat_grantB_o   = stat_b_q;
   assign stat_conflict_o = stat_c_q;
`endif

endmodule
